// File: rtl/axis_frame_receiver.sv
// AXI4-Stream video frame receiver.
// Consumes a SOF/EOF framed pixel stream, recovers the (x, y) coordinate of
// every accepted pixel, checks frame geometry against H_RES x V_RES and
// reports completed frames plus sync and length errors.
//
// H_RES and V_RES must both be at least 2 so that the first and last pixel of
// a frame are distinct positions.

module axis_frame_receiver #(
  parameter int unsigned H_RES      = 1024,
  parameter int unsigned V_RES      = 768,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned X_WIDTH    = $clog2(H_RES),
  parameter int unsigned Y_WIDTH    = $clog2(V_RES),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  // AXI4-Stream slave; TKEEP, TID and TDEST carry nothing this block needs
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,

  input  logic                  ready_i,

  output logic                  pix_valid_o,
  output logic [X_WIDTH-1:0]    pix_x_o,
  output logic [Y_WIDTH-1:0]    pix_y_o,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  frame_done_o,
  output logic                  err_sync_o,
  output logic                  err_len_o,
  output logic                  locked_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam logic [X_WIDTH-1:0] XLast = X_WIDTH'(H_RES - 1);
  localparam logic [Y_WIDTH-1:0] YLast = Y_WIDTH'(V_RES - 1);

  typedef enum logic [0:0] {
    StHunt,
    StLocked
  } state_e;

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    ex_q, ex_d;
  logic [Y_WIDTH-1:0]    ey_q, ey_d;

  logic                  pix_valid_q;
  logic [X_WIDTH-1:0]    pix_x_q;
  logic [Y_WIDTH-1:0]    pix_y_q;
  logic [DATA_WIDTH-1:0] pix_data_q;
  logic                  frame_done_q;
  logic                  err_sync_q;
  logic                  err_len_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;

  logic                  beat;
  logic                  sof;
  logic                  at_origin;
  logic [X_WIDTH-1:0]    eff_x;
  logic [Y_WIDTH-1:0]    eff_y;
  logic                  is_last;
  logic                  process;
  logic                  sync_err;
  logic                  len_err;
  logic                  done;
  logic                  err_any;

  // Only TUSER[0] (SOF) has meaning; the upper bits are tied off here.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // No back-pressure of our own: the stream is accepted whenever downstream is.
  assign s_axis_tready = ready_i;

  // Classify the current beat and work out the next expected position and state.
  always_comb begin
    beat      = s_axis_tvalid & ready_i;
    sof       = s_axis_tuser[0];
    at_origin = (ex_q == '0) && (ey_q == '0);

    // SOF always pins the beat to the frame origin, which is what resyncs us.
    eff_x   = sof ? '0 : ex_q;
    eff_y   = sof ? '0 : ey_q;
    is_last = (eff_x == XLast) && (eff_y == YLast);

    process  = 1'b0;
    sync_err = 1'b0;
    len_err  = 1'b0;
    done     = 1'b0;
    state_d  = state_q;
    ex_d     = ex_q;
    ey_d     = ey_q;

    if (beat) begin
      case (state_q)
        StHunt: begin
          process = sof;
        end
        StLocked: begin
          if (sof) begin
            process  = 1'b1;
            sync_err = !at_origin;
          end else if (at_origin) begin
            // A new frame must open with SOF; drop the beat and go looking.
            sync_err = 1'b1;
            state_d  = StHunt;
          end else begin
            process = 1'b1;
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end

    if (process) begin
      if (s_axis_tlast && is_last) begin
        done    = 1'b1;
        state_d = StLocked;
        ex_d    = '0;
        ey_d    = '0;
      end else if (s_axis_tlast || is_last) begin
        // Early EOF or missing EOF: geometry is untrustworthy, rehunt.
        len_err = 1'b1;
        state_d = StHunt;
        ex_d    = '0;
        ey_d    = '0;
      end else begin
        state_d = StLocked;
        if (eff_x == XLast) begin
          ex_d = '0;
          ey_d = eff_y + 1'b1;
        end else begin
          ex_d = eff_x + 1'b1;
          ey_d = eff_y;
        end
      end
    end

    // A resync beat that also ends early still counts as one erroneous beat.
    err_any = sync_err | len_err;
  end

  // Frame tracking state, registered pixel/event outputs and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StHunt;
      ex_q         <= '0;
      ey_q         <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_sync_q   <= 1'b0;
      err_len_q    <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      pix_valid_q  <= process;
      frame_done_q <= done;
      err_sync_q   <= sync_err;
      err_len_q    <= len_err;
      // Pixel fields hold their last value between strobes.
      if (process) begin
        pix_x_q    <= eff_x;
        pix_y_q    <= eff_y;
        pix_data_q <= s_axis_tdata;
      end
      if (done) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (err_any && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign pix_valid_o  = pix_valid_q;
  assign pix_x_o      = pix_x_q;
  assign pix_y_o      = pix_y_q;
  assign pix_data_o   = pix_data_q;
  assign frame_done_o = frame_done_q;
  assign err_sync_o   = err_sync_q;
  assign err_len_o    = err_len_q;
  assign locked_o     = (state_q == StLocked);
  assign frame_cnt_o  = frame_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_axis_frame_receiver.sv
// Directed self-checking bench for axis_frame_receiver on a 4x3 frame.

module tb_axis_frame_receiver;

  localparam int unsigned HRes = 4;
  localparam int unsigned VRes = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [15:0] tdata = '0;
  logic [0:0]  tuser = '0;
  logic        tlast = 1'b0;
  logic        ready = 1'b0;

  logic        pix_valid;
  logic [1:0]  pix_x;
  logic [1:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_done;
  logic        err_sync;
  logic        err_len;
  logic        locked;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int total = 0;
  int bad = 0;

  axis_frame_receiver #(
    .H_RES      (HRes),
    .V_RES      (VRes),
    .DATA_WIDTH (16),
    .USER_WIDTH (1),
    .CNT_WIDTH  (16)
  ) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .ready_i       (ready),
    .pix_valid_o   (pix_valid),
    .pix_x_o       (pix_x),
    .pix_y_o       (pix_y),
    .pix_data_o    (pix_data),
    .frame_done_o  (frame_done),
    .err_sync_o    (err_sync),
    .err_len_o     (err_len),
    .locked_o      (locked),
    .frame_cnt_o   (frame_cnt),
    .err_cnt_o     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Assert reset away from a clock edge and check that everything clears at once.
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sync", err_sync, 0);
    check("rst_err_len", err_len, 0);
    check("rst_locked", locked, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Present one beat (optionally after stall cycles) and check the registered result.
  task automatic beat(input logic u, input logic l, input logic [15:0] d, input int stalls,
                      input logic epv, input int exx, input int eyy, input logic edone,
                      input logic esync, input logic elen, input logic elock);
    tvalid = 1'b1;
    tuser  = u;
    tlast  = l;
    tdata  = d;
    for (int s = 0; s < stalls; s++) begin
      ready = 1'b0;
      @(posedge clk);
      #1;
      check("stall_tready", tready, 0);
      check("stall_pix_valid", pix_valid, 0);
      check("stall_frame_done", frame_done, 0);
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tuser  = '0;
    tlast  = 1'b0;
    check("pix_valid", pix_valid, epv);
    if (epv) begin
      check("pix_x", pix_x, exx);
      check("pix_y", pix_y, eyy);
      check("pix_data", pix_data, d);
    end
    check("frame_done", frame_done, edone);
    check("err_sync", err_sync, esync);
    check("err_len", err_len, elen);
    check("locked", locked, elock);
  endtask

  // A complete clean 4x3 frame, with up to stall_max stall cycles before each beat.
  task automatic frame(input int stall_max, input logic [15:0] base);
    for (int i = 0; i < 12; i++) begin
      beat(i == 0, i == 11, base + 16'(i), $urandom_range(0, stall_max),
           1'b1, i % 4, i / 4, i == 11, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Reset state
    do_reset();

    // Two clean back-to-back frames
    frame(0, 16'h1000);
    frame(0, 16'h2000);
    check("t1_frame_cnt", frame_cnt, 2);
    check("t1_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    check("t1_idle_pix_valid", pix_valid, 0);
    check("t1_idle_frame_done", frame_done, 0);
    check("t1_idle_locked", locked, 1);

    // Beats before the first SOF are dropped silently
    do_reset();
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, 1'b0, 16'h3000 + 16'(k), 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame(0, 16'h3100);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_err_cnt", err_cnt, 0);

    // Early EOF on beat 7 at (2,1)
    do_reset();
    for (int i = 0; i < 7; i++) begin
      beat(i == 0, i == 6, 16'h4000 + 16'(i), 0, 1'b1, i % 4, i / 4, 1'b0, 1'b0,
           i == 6, i != 6);
    end
    check("t3_err_cnt", err_cnt, 1);
    frame(0, 16'h4100);
    check("t3_frame_cnt", frame_cnt, 1);
    check("t3_err_cnt_after", err_cnt, 1);

    // Missing EOF on beat 12, then a stray TLAST beat in HUNT
    do_reset();
    for (int i = 0; i < 12; i++) begin
      beat(i == 0, 1'b0, 16'h5000 + 16'(i), 0, 1'b1, i % 4, i / 4, 1'b0, 1'b0,
           i == 11, i != 11);
    end
    beat(1'b0, 1'b1, 16'h5fff, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_frame_cnt", frame_cnt, 0);

    // SOF on beat 6 resynchronises to (0,0)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(i == 0, 1'b0, 16'h6000 + 16'(i), 0, 1'b1, i % 4, i / 4, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    beat(1'b1, 1'b0, 16'h6100, 0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < 12; p++) begin
      beat(1'b0, p == 11, 16'h6100 + 16'(p), 0, 1'b1, p % 4, p / 4, p == 11, 1'b0, 1'b0,
           1'b1);
    end
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_err_cnt", err_cnt, 1);

    // Random ready stalls, then reset in the middle of a frame
    do_reset();
    frame(2, 16'h7000);
    check("t6_frame_cnt", frame_cnt, 1);
    check("t6_err_cnt", err_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      beat(i == 0, 1'b0, 16'h7100 + 16'(i), $urandom_range(0, 2), 1'b1, i % 4, i / 4,
           1'b0, 1'b0, 1'b0, 1'b1);
    end
    do_reset();
    beat(1'b0, 1'b0, 16'h7200, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(0, 16'h7300);
    check("t6_frame_cnt_after", frame_cnt, 1);
    check("t6_err_cnt_after", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_receiver.md
# axis_frame_receiver

AXI4-Stream video frame receiver: the slave-side counterpart of the frame streamer. It consumes a pixel stream framed by TUSER (start of frame) and TLAST (end of frame), and recovers the (x, y) coordinate of every accepted pixel. It checks the frame geometry against H_RES × V_RES, resynchronises on start-of-frame, and reports frame completion and sync/length errors. It sits in front of framebuffer writers, video checkers and loopback test benches.

## Interface
- H_RES, 1024: pixels per line; must be ≥ 2.
- V_RES, 768: lines per frame; must be ≥ 2.
- DATA_WIDTH, 16: TDATA width.
- USER_WIDTH, 1: TUSER width; only bit 0 (SOF) is interpreted.
- X_WIDTH, $clog2(H_RES): x coordinate width.
- Y_WIDTH, $clog2(V_RES): y coordinate width.
- CNT_WIDTH, 16: width of the frame and error counters.
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- s_axis  axi4s_if.slave  —  TVALID, TREADY, TDATA, TUSER, TLAST used; TKEEP, TID and TDEST ignored.
- ready_i  in  1  downstream accept enable.
- pix_valid_o  out  1  registered pixel strobe.
- pix_x_o  out  X_WIDTH  pixel x.
- pix_y_o  out  Y_WIDTH  pixel y.
- pix_data_o  out  DATA_WIDTH  pixel data.
- frame_done_o  out  1  one-cycle pulse on a correctly terminated frame.
- err_sync_o  out  1  one-cycle pulse on a SOF error.
- err_len_o  out  1  one-cycle pulse on an EOF/length error.
- locked_o  out  1  high while in LOCKED.
- frame_cnt_o  out  CNT_WIDTH  count of good frames; wraps.
- err_cnt_o  out  CNT_WIDTH  count of erroneous beats; saturates at all-ones.

## Operation
- TREADY = ready_i, combinational. No other gating. A beat is TVALID && TREADY at a rising edge.
- Internal expected position (ex, ey) is reset to (0,0).
- **Effective position of a beat:** (0,0) if TUSER[0]=1, otherwise (ex, ey).
- **State HUNT:**
  - A beat without TUSER is discarded, with no outputs.
  - A beat with TUSER is processed at (0,0), and the state goes to LOCKED.
- **State LOCKED:**
  - A beat with TUSER while (ex, ey) ≠ (0,0): err_sync_o pulses and the beat is processed at (0,0) (resync). The state stays LOCKED.
  - A beat without TUSER while (ex, ey) = (0,0): err_sync_o pulses, the beat is discarded, and the state goes to HUNT.
- **Processing a beat at effective position (x, y):**
  - pix_valid_o is asserted with x, y and TDATA.
  - Let last = (x = H_RES-1 && y = V_RES-1).
  - TLAST && last: frame_done_o pulses, frame_cnt_o increments, (ex, ey) ← (0,0), and the state stays LOCKED.
  - TLAST && !last (early EOF): err_len_o pulses and the state goes to HUNT.
  - !TLAST && last (missing EOF): err_len_o pulses and the state goes to HUNT. No frame_done_o.
  - Otherwise (ex, ey) advances: x wraps to 0 at H_RES-1 and y increments.
- err_cnt_o increments once per beat that raises err_sync_o or err_len_o (at most one per beat).
- Entering HUNT resets (ex, ey) to (0,0).

## Timing
- All outputs are registered.
- A beat accepted at edge N drives pix_*, frame_done_o, err_* and the counter updates visible after edge N. Latency is 1 cycle.
- Throughput is one beat per cycle; there are no bubbles.
- pix_valid_o, frame_done_o, err_sync_o and err_len_o are high for exactly one cycle per event. They deassert in cycles with no beat.
- locked_o follows the state register and updates with the same 1-cycle latency.
- While TVALID=1 and TREADY=0, no state changes.
- **Reset:** asynchronous assertion at any time, including mid-frame or mid-beat. The block takes the following values immediately:
  - state = HUNT;
  - all outputs = 0 (pix_x_o, pix_y_o and pix_data_o included);
  - both counters = 0;
  - (ex, ey) = (0,0).
- Deassertion is synchronised by the reset tree outside the block. The first beat after reset must carry TUSER to be accepted.

## Test plan
(H_RES=4, V_RES=3, DATA_WIDTH=16 unless stated.)
- Two clean frames, TVALID=1, ready_i=1 → 24 pix_valid_o pulses with x 0..3 and y 0..2 in order. frame_done_o on beats 12 and 24. frame_cnt_o=2, err_cnt_o=0, locked_o=1 from the cycle after beat 1.
- 5 beats without TUSER, then a clean frame → first 5 beats dropped with no pix_valid_o. Then 12 pixels, frame_cnt_o=1, no errors.
- Clean frame with TLAST on beat 7, at (2,1) → pixel (2,1) emitted, err_len_o pulse, locked_o=0, err_cnt_o=1. The next TUSER frame completes with frame_cnt_o=1.
- TLAST missing on beat 12, then TLAST on the following beat without TUSER → err_len_o on beat 12 with no frame_done_o. The next beat is discarded in HUNT, err_cnt_o=1.
- TUSER on beat 6 of a frame → err_sync_o pulse and pix at (0,0). frame_done_o arrives 11 beats later, and frame_cnt_o increments.
- ready_i toggling randomly under continuous TVALID, plus rst_ni low mid-frame → pixel sequence identical to the stalled-free run. Reset forces all outputs to 0 immediately, and HUNT behaviour is seen afterwards.
